sram1rw_port_ctrl: RTL and testbench

SRAM1RW_PORT_CTRL -- requirements
Module: sram1rw_port_ctrl

---
 rtl/sram1rw_port_ctrl.sv | 130 +++++++++++++
 tb/tb_sram1rw_port_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram1rw_port_ctrl.sv
// sram1rw_port_ctrl
// ------------------------------------------------------------------
// Request/response front end for a single-port (1RW) SRAM macro.
// One request (read or write) is accepted per clock. The macro pins are
// driven combinationally from the accepted request, so the macro samples
// them on the same edge that accepts it. The macro returns read data one
// edge later. That data is captured into a small response FIFO, which
// gives a two-edge read latency. A read is accepted only when the FIFO is
// guaranteed to have room for its data, so accepted reads are never lost.
//
// Ports
//   clock        sole clock (also the macro CE clock)
//   reset        asynchronous, active-high reset
//   req_valid    request present
//   req_ready    request accepted on an edge where req_valid & req_ready
//   req_we       1 = write, 0 = read
//   req_addr     word address            [ADDR_W]
//   req_wdata    write data              [DATA_W]
//   resp_valid   read data available
//   resp_ready   consumer accepts the head response
//   resp_rdata   read data, in request order [DATA_W]
//   sram_csb     macro chip select, active low
//   sram_web     macro write enable, active low
//   sram_oeb     macro output enable, active low
//   sram_a       macro address           [ADDR_W]
//   sram_i       macro write data        [DATA_W]
//   sram_o       macro read data         [DATA_W]
// ------------------------------------------------------------------
module sram1rw_port_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic              fire;
  logic              rd_fire;
  logic              push;
  logic              pop;
  logic              inflight;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];

  // Credit check: the FIFO slots that will still be committed after this
  // edge are the stored entries plus the read whose data is arriving, less
  // the entry popped now. A new read needs one free slot beyond that.
  // Writes never need a slot. Reset masks acceptance so no macro access
  // can start while reset is held.
  always_comb begin
    credit_used = {1'b0, count}
                + {{CNT_W{1'b0}}, inflight}
                - {{CNT_W{1'b0}}, pop};
    req_ready   = ~reset & (req_we | (credit_used < (CNT_W+1)'(RESP_DEPTH)));
  end

  assign fire    = req_valid & req_ready;
  assign rd_fire = fire & ~req_we;
  assign push    = inflight;
  assign pop     = resp_valid & resp_ready;

  // The macro pins follow the request directly, with no register stage.
  assign sram_csb = ~fire;
  assign sram_web = ~(fire & req_we);
  assign sram_oeb = ~(fire & ~req_we);
  assign sram_a   = req_addr;
  assign sram_i   = req_wdata;

  assign resp_valid = (count != '0);
  assign resp_rdata = fifo_mem[rd_ptr];

  // inflight marks that the macro is presenting read data this cycle. That
  // data is captured at the next edge, so the flag lives for exactly one
  // cycle per accepted read. Back-to-back reads keep it set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_fire;
    end
  end

  // Circular FIFO bookkeeping. The pointers wrap naturally because the
  // depth is a power of two. Count moves only when push and pop differ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset. Entries are only visible through resp_rdata
  // once count says they were written.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sram_o;
    end
  end

endmodule

// File: tb/tb_sram1rw_port_ctrl.sv
// tb_sram1rw_port_ctrl
// ------------------------------------------------------------------
// Directed bench for sram1rw_port_ctrl with a behavioural 1RW macro.
// A reference memory is updated whenever a write is accepted. Each
// accepted read pushes its expected word into a scoreboard queue, and
// every popped response is compared with the head of that queue.
// Ports: none (top-level bench).
// ------------------------------------------------------------------
module tb_sram1rw_port_ctrl;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int RESP_DEPTH = 2;

  logic              clock;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              sram_csb;
  logic              sram_web;
  logic              sram_oeb;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_i;
  logic [DATA_W-1:0] sram_o;

  logic [DATA_W-1:0] macro_mem [1 << ADDR_W];
  logic [DATA_W-1:0] ref_mem   [1 << ADDR_W];
  logic [DATA_W-1:0] sb_q [$];

  int vectors     = 0;
  int miscompares = 0;

  sram1rw_port_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb),
    .sram_a    (sram_a),
    .sram_i    (sram_i),
    .sram_o    (sram_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural macro: it samples its pins on the rising edge and presents
  // read data after that edge. Its contents start as a known pattern that
  // the block itself never initialises.
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      macro_mem[i] <= 32'hA5000000 ^ (32'(i) * 32'h00010203);
      ref_mem[i]    = 32'hA5000000 ^ (32'(i) * 32'h00010203);
    end
  end

  always @(posedge clock) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        macro_mem[sram_a] <= sram_i;
      end else if (!sram_oeb) begin
        sram_o <= macro_mem[sram_a];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One cycle of stimulus: drive just after the rising edge, then return
  // at the falling edge so the caller can sample outputs.
  task automatic applyStimulus(input logic v, input logic we,
                               input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic rr);
    @(posedge clock);
    #1;
    req_valid  = v;
    req_we     = we;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = rr;
    @(negedge clock);
  endtask

  // Scoreboard monitor. Inputs are stable at the falling edge, so the
  // handshakes seen here are exactly the ones taken at the next rising edge.
  always @(negedge clock) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_underflow", 32'd1, 32'd0);
        end else begin
          checkOutput("resp_rdata", resp_rdata, sb_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          ref_mem[req_addr] = req_wdata;
        end else begin
          sb_q.push_back(ref_mem[req_addr]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state, with a read request held to show acceptance is gated.
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    @(negedge clock);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_csb", 32'(sram_csb), 32'd1);
    checkOutput("rst_web", 32'(sram_web), 32'd1);
    checkOutput("rst_oeb", 32'(sram_oeb), 32'd1);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;

    // Write 0xDEADBEEF @5, then read it back on the next edge.
    applyStimulus(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 1'b1);
    checkOutput("wr_csb", 32'(sram_csb), 32'd0);
    checkOutput("wr_web", 32'(sram_web), 32'd0);
    checkOutput("wr_oeb", 32'(sram_oeb), 32'd1);
    applyStimulus(1'b1, 1'b0, 6'd5, 32'h0, 1'b1);
    checkOutput("rd_csb", 32'(sram_csb), 32'd0);
    checkOutput("rd_oeb", 32'(sram_oeb), 32'd0);
    checkOutput("rd_web", 32'(sram_web), 32'd1);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
    checkOutput("lat1_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("idle_csb", 32'(sram_csb), 32'd1);
    checkOutput("idle_oeb", 32'(sram_oeb), 32'd1);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
    checkOutput("lat2_resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("lat2_rdata", resp_rdata, 32'hDEADBEEF);

    // Back-to-back reads @0..@7: one accepted per cycle, and responses on
    // consecutive cycles starting two cycles later.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(k < 8, 1'b0, 6'(k), 32'h0, 1'b1);
      if (k < 8) checkOutput($sformatf("b2b_ready_%0d", k), 32'(req_ready), 32'd1);
      checkOutput($sformatf("b2b_valid_%0d", k), 32'(resp_valid), 32'(k >= 2));
    end

    // Consumer stalled: only two reads fit, then reads back off.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 6'(8 + k), 32'h0, 1'b0);
      checkOutput($sformatf("stall_ready_%0d", k), 32'(req_ready), 32'(k < 2));
    end
    checkOutput("stall_resp_valid", 32'(resp_valid), 32'd1);
    // A write still goes through while the FIFO is full.
    applyStimulus(1'b1, 1'b1, 6'd20, 32'h12345678, 1'b0);
    checkOutput("full_wr_ready", 32'(req_ready), 32'd1);
    checkOutput("full_wr_web", 32'(sram_web), 32'd0);
    // Full FIFO: pop and a new read in the same cycle.
    applyStimulus(1'b1, 1'b0, 6'd20, 32'h0, 1'b1);
    checkOutput("full_pop_rd_ready", 32'(req_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 6'd21, 32'h0, 1'b0);
    checkOutput("refill_ready", 32'(req_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 6'd21, 32'h0, 1'b1);
    checkOutput("resume_ready_a", 32'(req_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 6'd22, 32'h0, 1'b1);
    checkOutput("resume_ready_b", 32'(req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
    end
    checkOutput("drain_resp_valid", 32'(resp_valid), 32'd0);

    // Reset pulsed one cycle after a read is accepted: its data is dropped.
    applyStimulus(1'b1, 1'b0, 6'd3, 32'h0, 1'b1);
    @(posedge clock);
    #1;
    reset     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 6'd4;
    @(negedge clock);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("midrst_csb", 32'(sram_csb), 32'd1);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clock);
    checkOutput("postrst_resp_valid", 32'(resp_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 6'd5, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
    checkOutput("postrst_lat1", 32'(resp_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
    checkOutput("postrst_lat2", 32'(resp_valid), 32'd1);
    checkOutput("postrst_rdata", resp_rdata, 32'hDEADBEEF);

    // Address boundaries, then a random mix to wrap the FIFO pointers.
    applyStimulus(1'b1, 1'b1, 6'd63, 32'hCAFEF00D, 1'b1);
    applyStimulus(1'b1, 1'b0, 6'd63, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 6'd0, 32'h0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                    6'($urandom_range(0, 63)), $urandom,
                    1'($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
    end
    checkOutput("end_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("end_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
